// File: rtl/gray_code_pkg.sv
// Shared types and helpers for the pipelined Gray/binary converter.
package gray_code_pkg;

    // Widest supported code word. Stage payloads are sized for this width;
    // narrower instances leave the upper bits at zero.
    localparam int MAX_W = 32;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    // Payload carried between stages. While a Gray word is being decoded,
    // data holds the already resolved binary bits and pend holds the Gray
    // bits that are still waiting to be resolved.
    typedef struct packed {
        logic [MAX_W-1:0] data;
        logic [MAX_W-1:0] pend;
        logic             mode;
        logic             adj_err;
    } stage_pl_t;

    // Works for any width up to MAX_W as long as the unused upper bits are zero.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [MAX_W-1:0] x);
        return (x & (x - MAX_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline stage: resolves Gray bits HI..LO (MSB first) and owns its
// valid bit. The first stage also performs the whole binary-to-Gray step.
module gray_pipe_stage
    import gray_code_pkg::*;
#(
    parameter int HI    = 0,
    parameter int LO    = 0,
    parameter bit FIRST = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      up_valid_i,
    input  stage_pl_t up_pl_i,
    input  logic      dn_adv_i,
    output logic      adv_o,
    output logic      valid_o,
    output stage_pl_t pl_o
);

    logic          valid_q;
    stage_pl_t     pl_q;
    stage_pl_t     pl_d;
    logic [MAX_W:0] bx;

    // A stage may take a new word when it is empty or its word moves on.
    assign adv_o   = !valid_q || dn_adv_i;
    assign valid_o = valid_q;
    assign pl_o    = pl_q;

    // Resolve this stage's slice of the prefix XOR chain; bx[MAX_W] is the
    // zero above the MSB, so the top bit needs no special case.
    always_comb begin
        pl_d = up_pl_i;
        bx   = {1'b0, up_pl_i.data};
        if (up_pl_i.mode == MODE_G2B) begin
            for (int i = MAX_W - 1; i >= 0; i--) begin
                if (i >= LO && i <= HI) begin
                    bx[i]        = bx[i+1] ^ up_pl_i.pend[i];
                    pl_d.pend[i] = 1'b0;
                end
            end
            pl_d.data = bx[MAX_W-1:0];
        end else if (FIRST) begin
            pl_d.data = bin2gray(up_pl_i.data);
        end
    end

    // Stage register; payload only loads with a real word so a stalled or
    // drained output keeps its last value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else if (adv_o) begin
            valid_q <= up_valid_i;
            if (up_valid_i) begin
                pl_q <= pl_d;
            end
        end
    end

endmodule

// File: rtl/gray_code_pipe.sv
// Pipelined Gray<->binary converter with valid/ready flow control and a
// Gray-adjacency monitor on the decode direction.
module gray_code_pipe
    import gray_code_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter bit CHECK_ADJ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err,
    output logic [7:0]       err_count
);

    localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_adv;
    logic [STAGES-1:0] dn_adv;
    stage_pl_t         stg_pl [STAGES];
    stage_pl_t         in_pl;
    logic              accept;
    logic              adj_flag;
    logic              unused_ok;

    assign in_ready = stg_adv[0];
    assign accept   = in_valid && in_ready;

    // Format the incoming word: Gray goes to pend for decoding, binary to data.
    always_comb begin
        in_pl         = '0;
        in_pl.mode    = in_mode;
        in_pl.adj_err = adj_flag;
        if (in_mode == MODE_G2B) begin
            in_pl.pend = MAX_W'(in_data);
        end else begin
            in_pl.data = MAX_W'(in_data);
        end
    end

    // Downstream of stage k advances if the output is taken or any later
    // stage has a hole; flattened from the valid bits to avoid a ready chain.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            dn_adv[k] = out_ready;
            for (int j = k + 1; j < STAGES; j++) begin
                if (!stg_valid[j]) begin
                    dn_adv[k] = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI     = WIDTH - 1 - k * SLICE;
        localparam int LO_RAW = WIDTH - (k + 1) * SLICE;
        localparam int LO     = (k == STAGES - 1 || LO_RAW < 0) ? 0 : LO_RAW;
        if (k == 0) begin : g_first
            gray_pipe_stage #(.HI(HI), .LO(LO), .FIRST(1'b1)) u_stage (
                .clk_i      (clk),
                .rst_i      (rst),
                .up_valid_i (in_valid),
                .up_pl_i    (in_pl),
                .dn_adv_i   (dn_adv[k]),
                .adv_o      (stg_adv[k]),
                .valid_o    (stg_valid[k]),
                .pl_o       (stg_pl[k])
            );
        end else begin : g_next
            gray_pipe_stage #(.HI(HI), .LO(LO), .FIRST(1'b0)) u_stage (
                .clk_i      (clk),
                .rst_i      (rst),
                .up_valid_i (stg_valid[k-1]),
                .up_pl_i    (stg_pl[k-1]),
                .dn_adv_i   (dn_adv[k]),
                .adv_o      (stg_adv[k]),
                .valid_o    (stg_valid[k]),
                .pl_o       (stg_pl[k])
            );
        end
    end

    assign out_valid   = stg_valid[STAGES-1];
    assign out_data    = stg_pl[STAGES-1].data[WIDTH-1:0];
    assign out_mode    = stg_pl[STAGES-1].mode;
    assign out_adj_err = stg_pl[STAGES-1].adj_err;

    if (CHECK_ADJ) begin : g_adj
        logic [WIDTH-1:0] prev_q, prev_d;
        logic             hist_q, hist_d;
        logic [7:0]       err_cnt_q, err_cnt_d;

        // Flag a multi-bit jump against the last accepted Gray word; binary
        // words are never flagged and leave the history alone.
        always_comb begin
            prev_d   = prev_q;
            hist_d   = hist_q;
            adj_flag = (in_mode == MODE_G2B) && hist_q &&
                       popcount_gt1(MAX_W'(in_data ^ prev_q));
            if (accept && in_mode == MODE_G2B) begin
                prev_d = in_data;
                hist_d = 1'b1;
            end
        end

        // Count flagged words as they leave, saturating at all-ones.
        always_comb begin
            err_cnt_d = err_cnt_q;
            if (out_valid && out_ready && out_adj_err && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        // Monitor history and error counter registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                prev_q    <= '0;
                hist_q    <= 1'b0;
                err_cnt_q <= '0;
            end else begin
                prev_q    <= prev_d;
                hist_q    <= hist_d;
                err_cnt_q <= err_cnt_d;
            end
        end

        assign err_count = err_cnt_q;
    end else begin : g_no_adj
        assign adj_flag  = 1'b0;
        assign err_count = '0;
    end

    // Later stages' own advance outputs and the last stage's spare payload
    // bits have no consumer at this level.
    assign unused_ok = ^{stg_adv, stg_pl[STAGES-1].pend, stg_pl[STAGES-1].data};

endmodule

// File: tb/tb_gray_code_pipe.sv
// Directed bench for gray_code_pipe: a WIDTH=4/STAGES=2 instance for the
// functional scenarios and three WIDTH=16 instances for the latency sweep.
module tb_gray_code_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst;
    logic       in_valid, in_ready, in_mode;
    logic [3:0] in_data;
    logic       out_valid, out_ready, out_mode, out_adj_err;
    logic [3:0] out_data;
    logic [7:0] err_count;

    logic        sw_valid, sw_mode, sw_out_ready;
    logic [15:0] sw_data;
    logic        s1_in_ready, s1_valid, s1_mode, s1_adj;
    logic        s4_in_ready, s4_valid, s4_mode, s4_adj;
    logic        s16_in_ready, s16_valid, s16_mode, s16_adj;
    logic [15:0] s1_data, s4_data, s16_data;
    logic [7:0]  s1_cnt, s4_cnt, s16_cnt;

    gray_code_pipe #(.WIDTH(4), .STAGES(2), .CHECK_ADJ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
        .out_adj_err(out_adj_err), .err_count(err_count)
    );

    gray_code_pipe #(.WIDTH(16), .STAGES(1), .CHECK_ADJ(1'b1)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_in_ready),
        .in_data(sw_data), .in_mode(sw_mode), .out_valid(s1_valid),
        .out_ready(sw_out_ready), .out_data(s1_data), .out_mode(s1_mode),
        .out_adj_err(s1_adj), .err_count(s1_cnt)
    );

    gray_code_pipe #(.WIDTH(16), .STAGES(4), .CHECK_ADJ(1'b1)) u_sw4 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s4_in_ready),
        .in_data(sw_data), .in_mode(sw_mode), .out_valid(s4_valid),
        .out_ready(sw_out_ready), .out_data(s4_data), .out_mode(s4_mode),
        .out_adj_err(s4_adj), .err_count(s4_cnt)
    );

    gray_code_pipe #(.WIDTH(16), .STAGES(16), .CHECK_ADJ(1'b1)) u_sw16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s16_in_ready),
        .in_data(sw_data), .in_mode(sw_mode), .out_valid(s16_valid),
        .out_ready(sw_out_ready), .out_data(s16_data), .out_mode(s16_mode),
        .out_adj_err(s16_adj), .err_count(s16_cnt)
    );

    // One reset edge, returning on a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
        out_ready = 1'b1; sw_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode got=%b exp=0", out_mode); end
        checks++; if (out_adj_err !== 1'b0) begin errors++; $display("FAIL reset_adj_err got=%b exp=0", out_adj_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        rst = 1'b0;
    endtask

    task automatic test_g2b_stream();
        logic [3:0] g [6];
        logic [3:0] b [6];
        logic       f [6];
        int idx;
        g = '{4'b0000, 4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
        b = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
        f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int m = 0; m < 8; m++) begin
            if (m < 6) begin
                in_valid = 1'b1; in_mode = 1'b0; in_data = g[m];
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready word=%0d got=%b exp=1", m, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            idx = m - 1;
            checks++;
            if (idx >= 0 && idx < 6) begin
                if (out_valid !== 1'b1 || out_data !== b[idx] || out_adj_err !== f[idx] || out_mode !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_word%0d got v=%b d=%b e=%b m=%b exp v=1 d=%b e=%b m=0",
                             idx, out_valid, out_data, out_adj_err, out_mode, b[idx], f[idx]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++; $display("FAIL stream_idle cyc=%0d got v=%b exp v=0", m, out_valid);
            end
        end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL stream_err_count got=%0d exp=2", err_count); end
    endtask

    task automatic test_mode_mix();
        logic [3:0] d [2];
        logic [3:0] e [2];
        logic       md [2];
        int idx;
        d = '{4'b1011, 4'b1110};
        e = '{4'b1110, 4'b1011};
        md = '{1'b1, 1'b0};
        do_reset();
        for (int m = 0; m < 4; m++) begin
            if (m < 2) begin in_valid = 1'b1; in_mode = md[m]; in_data = d[m]; end
            else in_valid = 1'b0;
            @(negedge clk);
            idx = m - 1;
            checks++;
            if (idx >= 0 && idx < 2) begin
                if (out_valid !== 1'b1 || out_data !== e[idx] || out_mode !== md[idx] || out_adj_err !== 1'b0) begin
                    errors++;
                    $display("FAIL mode_mix%0d got v=%b d=%b m=%b e=%b exp v=1 d=%b m=%b e=0",
                             idx, out_valid, out_data, out_mode, out_adj_err, e[idx], md[idx]);
                end
            end else if (out_valid !== 1'b0) begin
                errors++; $display("FAIL mode_mix_idle cyc=%0d got v=%b exp v=0", m, out_valid);
            end
        end
    endtask

    task automatic test_adjacency();
        logic [3:0] d [7];
        logic [3:0] e [7];
        logic       md [7];
        logic       f [7];
        int n, idx;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                n = 4;
                d  = '{4'b0000, 4'b0001, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
                e  = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
                md = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
                f  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            end else begin
                n = 7;
                d  = '{4'b0000, 4'b1111, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0111};
                e  = '{4'b0000, 4'b1000, 4'b0001, 4'b0111, 4'b0001, 4'b0000, 4'b0101};
                md = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
                f  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            end
            do_reset();
            for (int m = 0; m < n + 2; m++) begin
                if (m < n) begin in_valid = 1'b1; in_mode = md[m]; in_data = d[m]; end
                else in_valid = 1'b0;
                @(negedge clk);
                idx = m - 1;
                checks++;
                if (idx >= 0 && idx < n) begin
                    if (out_valid !== 1'b1 || out_data !== e[idx] || out_adj_err !== f[idx]) begin
                        errors++;
                        $display("FAIL adj_p%0d_word%0d got v=%b d=%b e=%b exp v=1 d=%b e=%b",
                                 ph, idx, out_valid, out_data, out_adj_err, e[idx], f[idx]);
                    end
                end else if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL adj_p%0d_idle got v=%b exp v=0", ph, out_valid);
                end
            end
            checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL adj_p%0d_err_count got=%0d exp=1", ph, err_count); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] g [4];
        logic [3:0] b [4];
        logic [3:0] hold;
        logic       seen;
        int widx;
        g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
        b = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};
        do_reset();
        out_ready = 1'b0;
        widx = 0;
        seen = 1'b0;
        hold = '0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_mode = 1'b0; in_data = g[widx];
            if (in_ready === 1'b1) widx++;
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1; hold = out_data;
                end else begin
                    checks++;
                    if (out_data !== hold) begin errors++; $display("FAIL bp_hold cyc=%0d got=%b exp=%b", c, out_data, hold); end
                end
            end
        end
        checks++; if (widx != 2) begin errors++; $display("FAIL bp_accepted got=%0d exp=2", widx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== b[0]) begin errors++; $display("FAIL bp_head got v=%b d=%b exp v=1 d=%b", out_valid, out_data, b[0]); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== b[1]) begin errors++; $display("FAIL bp_drain1 got v=%b d=%b exp v=1 d=%b", out_valid, out_data, b[1]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got v=%b exp v=0", out_valid); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL bp_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0000;
        @(negedge clk); in_data = 4'b0011;
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mid_pre_err_count got=%0d exp=1", err_count); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0001;
        @(negedge clk); in_data = 4'b0011;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count got=%0d exp=0", err_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 4'b0110;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_adj_err !== 1'b0) begin
            errors++; $display("FAIL mid_first_after got v=%b d=%b e=%b exp v=1 d=0100 e=0", out_valid, out_data, out_adj_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_mode = 1'b0;
            in_data = (i % 2 == 0) ? 4'b0000 : 4'b0011;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count got=%0d exp=255", err_count); end
    endtask

    task automatic test_sweep();
        logic [15:0] b_arr [1000];
        logic [15:0] dat;
        logic        v;
        int s, idx;
        for (int i = 0; i < 1000; i++) b_arr[i] = 16'($urandom_range(0, 65535));
        do_reset();
        sw_out_ready = 1'b1;
        for (int m = 0; m < 1017; m++) begin
            if (m < 1000) begin
                sw_valid = 1'b1; sw_mode = 1'b0; sw_data = b_arr[m] ^ (b_arr[m] >> 1);
            end else begin
                sw_valid = 1'b0;
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (d == 0) begin s = 1;  v = s1_valid;  dat = s1_data;  end
                else if (d == 1) begin s = 4;  v = s4_valid;  dat = s4_data;  end
                else begin s = 16; v = s16_valid; dat = s16_data; end
                idx = m - s + 1;
                checks++;
                if (idx >= 0 && idx < 1000) begin
                    if (v !== 1'b1 || dat !== b_arr[idx]) begin
                        errors++;
                        $display("FAIL sweep_s%0d_word%0d got v=%b d=%h exp v=1 d=%h", s, idx, v, dat, b_arr[idx]);
                    end
                end else if (v !== 1'b0) begin
                    errors++; $display("FAIL sweep_s%0d_idle cyc=%0d got v=%b exp v=0", s, m, v);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_mode = 1'b0; sw_data = '0; sw_out_ready = 1'b1;
        test_reset();
        test_g2b_stream();
        test_mode_mix();
        test_adjacency();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
